// File: rtl/hz_generator.sv
// Programmable square-wave source with a modulo-CLK_HZ phase accumulator, plus a
// 1 s high / 1 s low measurement gate for the companion frequency counter.
module hz_generator #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned FW     = 24
) (
  input  logic          ref_clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [FW-1:0] freq_hz,
  input  logic          load,
  output logic          ack,
  output logic          err,
  output logic          busy,
  output logic          wave_out,
  output logic          gate_out
);

  localparam int unsigned AW_MIN = $clog2(2 * CLK_HZ);
  localparam int unsigned AW     = (AW_MIN > FW + 1) ? AW_MIN : FW + 1;
  localparam int unsigned SW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [AW-1:0] MOD_W    = AW'(CLK_HZ);
  localparam logic [AW-1:0] HALF_W   = AW'(CLK_HZ / 2);
  localparam logic [SW-1:0] SEC_LAST = SW'(CLK_HZ - 1);

  logic [FW-1:0] active_q, active_d;
  logic [FW-1:0] pending_q, pending_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          wave_q, wave_d;
  logic          gate_q, gate_d;

  logic [AW-1:0] sum;
  logic          wrap;
  logic          load_ok;
  logic          load_bad;
  logic          immediate;

  always_comb begin
    active_d  = active_q;
    pending_d = pending_q;
    busy_d    = busy_q;
    acc_d     = acc_q;
    sec_d     = sec_q;
    wave_d    = wave_q;
    gate_d    = gate_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;

    sum       = acc_q + (AW'(active_q) << 1);
    wrap      = (sum >= MOD_W);
    load_ok   = load && (AW'(freq_hz) <= HALF_W);
    load_bad  = load && !load_ok;
    immediate = !enable || (active_q == '0);

    if (immediate) begin
      acc_d  = '0;
      wave_d = 1'b0;
    end else if (wrap) begin
      acc_d  = sum - MOD_W;
      wave_d = !wave_q;
    end else begin
      acc_d  = sum;
    end

    if (!enable) begin
      sec_d  = '0;
      gate_d = 1'b0;
    end else if (sec_q == SEC_LAST) begin
      sec_d  = '0;
      gate_d = !gate_q;
    end else begin
      sec_d  = sec_q + SW'(1);
    end

    // A rejected load holds off any apply for that edge so ack and err never
    // coincide; a deferred apply simply waits for the next rising toggle.
    err_d = load_bad;
    if (!load_bad) begin
      if (immediate) begin
        if (load_ok) begin
          pending_d = freq_hz;
          active_d  = freq_hz;
          acc_d     = '0;
          busy_d    = 1'b0;
          ack_d     = 1'b1;
        end else if (busy_q) begin
          active_d  = pending_q;
          acc_d     = '0;
          busy_d    = 1'b0;
          ack_d     = 1'b1;
        end
      end else begin
        if (busy_q && wrap && !wave_q) begin
          active_d = pending_q;
          acc_d    = '0;
          busy_d   = 1'b0;
          ack_d    = 1'b1;
        end
        if (load_ok) begin
          pending_d = freq_hz;
          busy_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= '0;
      pending_q <= '0;
      busy_q    <= 1'b0;
      acc_q     <= '0;
      sec_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      wave_q    <= 1'b0;
      gate_q    <= 1'b0;
    end else begin
      active_q  <= active_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      acc_q     <= acc_d;
      sec_q     <= sec_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      wave_q    <= wave_d;
      gate_q    <= gate_d;
    end
  end

  assign ack      = ack_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign wave_out = wave_q;
  assign gate_out = gate_q;

endmodule

// File: tb/tb_hz_generator.sv
// Scoreboard bench for hz_generator at CLK_HZ=1000: expected counts are queued as
// stimulus is applied and compared when the measured DUT behaviour is available.
module tb_hz_generator;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned FW     = 24;

  logic          ref_clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          load;
  logic [FW-1:0] freq_hz;
  logic          ack;
  logic          err;
  logic          busy;
  logic          wave_out;
  logic          gate_out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int unsigned exp_q[$];
  string       tag_q[$];

  int unsigned m_rises, m_acks, m_errs, m_busy, m_both;
  bit          got_ack, rose_at_ack;

  hz_generator #(.CLK_HZ(CLK_HZ), .FW(FW)) dut (
    .ref_clk  (ref_clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .freq_hz  (freq_hz),
    .load     (load),
    .ack      (ack),
    .err      (err),
    .busy     (busy),
    .wave_out (wave_out),
    .gate_out (gate_out)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int unsigned v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string       t;
    int unsigned e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_underflow: got %0d with no expected value queued", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic do_load(input int unsigned f);
    freq_hz = FW'(f);
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic measure(input int unsigned n);
    logic prev;
    m_rises = 0; m_acks = 0; m_errs = 0; m_busy = 0; m_both = 0;
    prev = wave_out;
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      if (wave_out && !prev) m_rises++;
      if (ack)               m_acks++;
      if (err)               m_errs++;
      if (busy)              m_busy++;
      if (ack && err)        m_both++;
      prev = wave_out;
    end
  endtask

  task automatic wait_ack(input int unsigned budget, input string tag);
    logic prev;
    got_ack     = 1'b0;
    rose_at_ack = 1'b0;
    prev = wave_out;
    for (int unsigned i = 0; i < budget && !got_ack; i++) begin
      tick();
      if (ack) begin
        got_ack     = 1'b1;
        rose_at_ack = wave_out && !prev;
      end
      prev = wave_out;
    end
    check(tag, got_ack, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; load = 1'b0; freq_hz = '0;
    #12;
    push("reset_outs", 0);
    pop_check({27'd0, ack, err, busy, wave_out, gate_out});
    tick(); tick();
    rst_n  = 1'b1;
    enable = 1'b1;

    // Gate timing and idle wave with no load
    push("gate_pre", 0); push("idle_rises", 0);
    measure(999);
    pop_check(gate_out); pop_check(m_rises);
    push("gate_rise", 1);
    tick(); pop_check(gate_out);
    push("gate_high", 1);
    measure(999); pop_check(gate_out);
    push("gate_fall", 0);
    tick(); pop_check(gate_out);

    // Immediate load of 100 Hz
    push("imm_ack", 1); push("imm_busy", 0);
    do_load(100);
    pop_check(ack); pop_check(busy);
    push("imm_wave_pre", 0); push("imm_acks_after", 0);
    measure(4);
    pop_check(wave_out); pop_check(m_acks);
    push("imm_first_rise", 1);
    tick(); pop_check(wave_out);
    push("imm_rises", 100); push("imm_busy_seen", 0);
    measure(1000);
    pop_check(m_rises); pop_check(m_busy);

    // Deferred load of 300 Hz
    push("def_busy", 1); push("def_no_ack", 0);
    do_load(300);
    pop_check(busy); pop_check(ack);
    push("def_rose", 1); push("def_busy_clr", 0);
    wait_ack(30, "def_ack_seen");
    pop_check(rose_at_ack); pop_check(busy);
    push("def_rises", 300); push("def_extra_ack", 0);
    measure(1000);
    pop_check(m_rises); pop_check(m_acks);

    // Maximum legal frequency
    push("max_busy", 1);
    do_load(500);
    pop_check(busy);
    wait_ack(30, "max_ack_seen");
    push("max_rises", 500);
    measure(1000);
    pop_check(m_rises);

    // Rejected load keeps 500 Hz running
    push("rej_err", 1); push("rej_ack", 0); push("rej_busy", 0);
    do_load(501);
    pop_check(err); pop_check(ack); pop_check(busy);
    push("rej_rises", 500); push("rej_errs", 0); push("rej_acks", 0);
    measure(1000);
    pop_check(m_rises); pop_check(m_errs); pop_check(m_acks);

    // Zero frequency
    do_load(0);
    wait_ack(10, "zero_ack_seen");
    measure(2);
    push("zero_rises", 0); push("zero_wave", 0);
    measure(100);
    pop_check(m_rises); pop_check(wave_out);

    // Overwrite: 200 then 250 while running at 10
    push("ten_ack", 1);
    do_load(10);
    pop_check(ack);
    measure(30);
    do_load(200);
    do_load(250);
    push("ovw_busy", 1);
    pop_check(busy);
    wait_ack(200, "ovw_ack_seen");
    push("ovw_single_ack", 0); push("ovw_rises", 250); push("ovw_both", 0);
    measure(1000);
    pop_check(m_acks); pop_check(m_rises); pop_check(m_both);

    // Disable mid-period while wave and gate are both high
    begin
      bit hit = 1'b0;
      for (int unsigned i = 0; i < 2500 && !hit; i++) begin
        tick();
        if (wave_out && gate_out) hit = 1'b1;
      end
      check("dis_found_high", hit, 1);
    end
    enable = 1'b0;
    push("dis_wave", 0); push("dis_gate", 0);
    tick();
    pop_check(wave_out); pop_check(gate_out);

    // Load while disabled applies at once; re-enable restarts the gate
    push("dis_load_ack", 1); push("dis_load_busy", 0);
    do_load(100);
    pop_check(ack); pop_check(busy);
    enable = 1'b1;
    push("reen_gate_pre", 0); push("reen_rises", 100);
    measure(999);
    pop_check(gate_out); pop_check(m_rises);
    push("reen_gate_rise", 1);
    tick(); pop_check(gate_out);

    // Asynchronous reset with a pending load
    push("rst_pend_busy", 1);
    do_load(400);
    pop_check(busy);
    #1;
    rst_n = 1'b0;
    #1;
    push("rst_async_outs", 0);
    pop_check({27'd0, ack, err, busy, wave_out, gate_out});
    tick(); tick();
    rst_n = 1'b1;
    push("rst_no_ack", 0); push("rst_rises", 0);
    measure(50);
    pop_check(m_acks); pop_check(m_rises);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hz_generator.md
# hz_generator

Programmable square-wave source and measurement-gate generator: the transmit-side companion of the frequency counter. From one system clock it produces `wave_out` at a programmed integer frequency in Hz, using a modulo-`CLK_HZ` phase accumulator so that the average frequency is exact. It also produces `gate_out`, a 1 s high / 1 s low window. Feeding `gate_out` to the counter's reference input and `wave_out` to its unknown input gives a self-test loop: the counter reads back the programmed value.

## Interface
- `CLK_HZ`, 100_000_000 — frequency of `ref_clk` in Hz; also the accumulator modulus and the gate half-period in cycles.
- `FW`, 24 — width of the frequency word.
- `ref_clk`  in  1  — system clock; all state updates on its rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `enable`  in  1  — run; low holds the wave and gate generators idle.
- `freq_hz`  in  FW  — requested output frequency in Hz; sampled only when `load`=1.
- `load`  in  1  — single-cycle request to program `freq_hz`.
- `ack`  out  1  — one-cycle pulse when a loaded frequency becomes active.
- `err`  out  1  — one-cycle pulse when a load is rejected.
- `busy`  out  1  — a pending frequency is waiting to be applied.
- `wave_out`  out  1  — square-wave output, 50 % duty on average.
- `gate_out`  out  1  — measurement window, high for exactly `CLK_HZ` cycles, then low for `CLK_HZ` cycles.

## Operation
- **Registers**
  - `active` (FW) — current frequency.
  - `pending` (FW) plus valid bit (drives `busy`).
  - `acc` — width ≥ ceil(log2(2·`CLK_HZ`)).
  - `sec_cnt` — counts 0..`CLK_HZ`-1.
  - All registered outputs.
- **Reset (async, `rst_n`=0)**
  - `active`, `pending`, `acc`, `sec_cnt` ← 0.
  - `busy`, `ack`, `err`, `wave_out`, `gate_out` ← 0.
  - Reset mid-operation discards the pending load with no `ack`.
- **Load validation**
  - `load`=1 and `freq_hz` > `CLK_HZ`/2 (integer division): `err`=1 next cycle; `pending` and `busy` unchanged.
  - Otherwise: `pending` ← `freq_hz`, `busy` ← 1.
  - A load while `busy`=1 overwrites `pending`. Only the last value is applied, with a single `ack`.
- **Apply rule** — `pending` → `active`, `acc` ← 0, `busy` ← 0, `ack` pulses, all on the same edge.
  - Immediately (the edge after the load) if `enable`=0 or `active`=0.
  - Otherwise, on the edge where `wave_out` toggles 0→1. The new period starts cleanly and there are no glitches or runt pulses.
  - A load on the apply edge itself is captured as a new pending value.
- **Wave generation** (`enable`=1, `active`≠0), each cycle:
  - sum = `acc` + 2·`active`.
  - If sum ≥ `CLK_HZ`: `acc` ← sum − `CLK_HZ` and `wave_out` toggles.
  - Otherwise: `acc` ← sum.
  - The constraint 2·`active` ≤ `CLK_HZ` guarantees at most one toggle per cycle.
  - Arithmetic is unsigned and carried out at accumulator width; no overflow is possible.
- **Zero frequency** — `active`=0: `acc` held at 0, `wave_out` ← 0.
- **Disable** — `enable`=0:
  - `acc` ← 0, `wave_out` ← 0, `sec_cnt` ← 0, `gate_out` ← 0 on the next edge.
  - `active` is retained and loads still accepted.
- **Gate generation** (`enable`=1)
  - `sec_cnt` increments; at `CLK_HZ`-1 it wraps to 0 and `gate_out` toggles.
  - The first high window therefore starts `CLK_HZ` cycles after `enable` is first sampled high.

## Timing
- All outputs registered. No combinational path from input to output.
- `ack` / `err` latency:
  - 1 cycle after `load` for an immediate apply or a reject.
  - Otherwise, the edge of the next `wave_out` rising toggle.
- First `wave_out` toggle after enable/apply: after ceil(`CLK_HZ`/(2·`active`)) enabled cycles.
- Exact averaging: over any `CLK_HZ` enabled cycles, `wave_out` makes exactly `active` rising transitions ±1.
- `ack` and `err` never assert together. Each is exactly one cycle wide.

## Test plan
- Reset with `CLK_HZ`=1000: release `rst_n`, `enable`=1, no load → `wave_out`=0 held; `gate_out` rises after cycle 1000 and falls after cycle 2000.
- Immediate load, `CLK_HZ`=1000: load 100 while idle → `ack` 1 cycle later; `wave_out` toggles every 5 cycles (period 10); `busy` never observed high after `ack`.
- Deferred load, `CLK_HZ`=1000: load 300 while running at 100 → `busy`=1 until the next 0→1 toggle; `ack` coincides with that toggle; exactly 300 rising edges per 1000 cycles thereafter.
- Boundaries, `CLK_HZ`=1000:
  - load 500 → `wave_out` toggles every cycle.
  - load 501 → `err` pulse, `active` unchanged, no `ack`.
  - load 0 → `wave_out` low.
- Overwrite and disable, `CLK_HZ`=1000:
  - loads 200 then 250 back-to-back while running at 10 → single `ack`, `active`=250.
  - drop `enable` mid-period → `wave_out`=0 and `gate_out`=0 next edge.
- Loop test: connect to the frequency counter with the default `CLK_HZ`, program 12345 → counter holds 12345 ±1 at the end of each `gate_out` high window; assert `rst_n` mid-window → all outputs 0 immediately.
